// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared constants, FSM state type and K clamp for the approximate multiplier
package approx_mult_pkg;

   localparam int OP_W   = 16;
   localparam int PROD_W = 32;
   localparam int CNT_W  = 4;
   localparam int K_MAX  = 16;
   localparam int K_W    = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A row only has OP_W columns, so larger K requests collapse to "all approximate"
   function automatic logic [K_W-1:0] sat_k(input logic [K_W-1:0] k);
      return (k > K_W'(K_MAX)) ? K_W'(K_MAX) : k;
   endfunction

endpackage

// File: rtl/approx_row_adder.sv
// rtl/approx_row_adder.sv - one 16-column adder row, low k columns approximate, stateless
module approx_row_adder
   import approx_mult_pkg::*;
(
   input  logic [OP_W-1:0] a,
   input  logic [OP_W-1:0] b,
   input  logic [K_W-1:0]  k,
   output logic [OP_W-1:0] sum,
   output logic            cout,
   output logic            hit
);

   // Ripple carry across columns; the approximate cell keeps the exact carry
   // but drops the sum bit when all three inputs are one, which is what hit flags
   always_comb begin : ripple
      logic c;
      logic maj;
      c    = 1'b0;
      maj  = 1'b0;
      sum  = '0;
      hit  = 1'b0;
      cout = 1'b0;
      for (int j = 0; j < OP_W; j++) begin
         maj = (a[j] & b[j]) | (a[j] & c) | (b[j] & c);
         if (j < int'(k)) begin
            sum[j] = (a[j] | b[j] | c) & ~maj;
            hit    = hit | (a[j] & b[j] & c);
         end else begin
            sum[j] = a[j] ^ b[j] ^ c;
         end
         c = maj;
      end
      cout = c;
   end

endmodule

// File: rtl/approx_mult_seq_ctrl.sv
// rtl/approx_mult_seq_ctrl.sv - sequential shift-add multiplier with run-time approximate low columns
module approx_mult_seq_ctrl
   import approx_mult_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_valid,
   output logic              start_ready,
   input  logic [OP_W-1:0]   op_a,
   input  logic [OP_W-1:0]   op_b,
   input  logic [K_W-1:0]    approx_k,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [PROD_W-1:0] product,
   output logic              approx_hit,
   output logic              busy
);

   state_t            state_q;
   state_t            state_d;
   logic [OP_W-1:0]   a_q;
   logic [OP_W-1:0]   b_q;
   logic [K_W-1:0]    k_q;
   logic [PROD_W:0]   acc_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              hit_q;

   logic [OP_W-1:0]   row_addend;
   logic [OP_W-1:0]   row_sum;
   logic              row_cout;
   logic              row_hit;
   logic              last_run;
   logic              unused_acc_msb;

   assign row_addend     = b_q[cnt_q] ? a_q : '0;
   assign last_run       = (cnt_q == CNT_W'(OP_W - 1));
   assign product        = (state_q == ST_DONE) ? acc_q[PROD_W-1:0] : '0;
   assign approx_hit     = hit_q;
   assign unused_acc_msb = acc_q[PROD_W];

   approx_row_adder u_row (
      .a    (acc_q[PROD_W-1:OP_W]),
      .b    (row_addend),
      .k    (k_q),
      .sum  (row_sum),
      .cout (row_cout),
      .hit  (row_hit)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; start_ready is masked while rst is held
   always_comb begin
      state_d     = state_q;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      busy        = 1'b1;
      case (state_q)
         ST_IDLE: begin
            busy        = 1'b0;
            start_ready = ~rst;
            if (start_valid) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (last_run) state_d = ST_DONE;
         end
         ST_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Operand latch on accept, one partial-product row per RUN cycle, shift right into acc
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         k_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         hit_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_valid) begin
                  a_q   <= op_a;
                  b_q   <= op_b;
                  k_q   <= sat_k(approx_k);
                  acc_q <= '0;
                  cnt_q <= '0;
                  hit_q <= 1'b0;
               end
            end
            ST_RUN: begin
               acc_q <= {row_cout, row_sum, acc_q[OP_W-1:0]} >> 1;
               hit_q <= hit_q | row_hit;
               cnt_q <= cnt_q + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
